// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared widths and types for the DCT multiply-accumulate path
package dct_pkg;

  localparam int DCT_N  = 8;
  localparam int DCT_DW = 8;
  localparam int DCT_CW = 12;
  localparam int DCT_RW = DCT_DW + DCT_CW + $clog2(DCT_N);

  typedef logic signed [DCT_DW-1:0] dct_sample_t;
  typedef logic signed [DCT_CW-1:0] dct_coef_t;
  typedef logic signed [DCT_RW-1:0] dct_res_t;

endpackage

// File: rtl/dct_mac_seq.sv
// rtl/dct_mac_seq.sv - sequential MAC producing one DCT result per N sample/coefficient pairs
module dct_mac_seq
  import dct_pkg::*;
#(
  parameter int DW = DCT_DW,
  parameter int CW = DCT_CW,
  parameter int N  = DCT_N,
  parameter int RW = DW + CW + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_x,
  input  logic [CW-1:0]        in_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RW-1:0]        out_res,
  output logic [$clog2(N)-1:0] out_cnt
);

  localparam int NB = $clog2(N);
  localparam int PW = DW + CW;

  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] c_ext;
  logic signed [PW-1:0] prod;
  logic signed [RW-1:0] acc;
  logic signed [RW-1:0] sum;
  logic [NB-1:0]        cnt;
  logic                 last_cnt;
  logic                 accept;

  // Operands are zeroed when no pair is offered so X on idle inputs never reaches acc.
  assign x_ext = in_valid ? {{CW{in_x[DW-1]}}, in_x} : '0;
  assign c_ext = in_valid ? {{DW{in_c[CW-1]}}, in_c} : '0;
  assign prod  = x_ext * c_ext;
  assign sum   = acc + {{(RW-PW){prod[PW-1]}}, prod};

  assign last_cnt = (cnt == NB'(N-1));
  // Only the closing pair of a vector waits, and only behind an unconsumed result.
  assign in_ready = !(last_cnt && out_valid && !out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign out_cnt  = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
    end else begin
      if (flush) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        if (last_cnt) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + NB'(1);
        end
      end

      if (accept && last_cnt) begin
        out_res   <= sum;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dct_mac_seq.sv
// tb/tb_dct_mac_seq.sv - directed, table-driven and scoreboard checks for dct_mac_seq
module tb_dct_mac_seq;
  import dct_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x = '0;
  logic [11:0] in_c = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [22:0] out_res;
  logic [2:0]  out_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int x;
    int c;
    int res;
  } vec_t;

  vec_t tbl[9];

  dct_mac_seq dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int c);
    int t = 0;
    in_valid = 1'b1;
    in_x = x[7:0];
    in_c = c[11:0];
    #1;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input int x, input int c);
    for (int i = 0; i < 8; i++) send(x, c);
  endtask

  dct_sample_t    sx;
  dct_coef_t      sc;
  longint         macc;
  int             mcnt;
  int             pairs;
  int             delivered;
  int             cycles;
  bit             tog;
  bit             fin;
  bit             fout;
  longint         exp_q[$];

  initial begin
    tbl[0] = '{x: 1,    c: 1,     res: 8};
    tbl[1] = '{x: -128, c: -2048, res: 2097152};
    tbl[2] = '{x: 127,  c: -2048, res: -2080768};
    tbl[3] = '{x: 2,    c: 3,     res: 48};
    tbl[4] = '{x: 1,    c: -1,    res: -8};
    tbl[5] = '{x: -1,   c: -1,    res: 8};
    tbl[6] = '{x: 0,    c: 5,     res: 0};
    tbl[7] = '{x: 127,  c: 127,   res: 129032};
    tbl[8] = '{x: -128, c: 2047,  res: -2096128};

    // reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_cnt", out_cnt, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // table-driven full vectors, out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send_vec(tbl[i].x, tbl[i].c);
      chk($sformatf("tbl%0d_valid", i), out_valid, 1);
      chk($sformatf("tbl%0d_res", i), $signed(out_res), tbl[i].res);
      step();
      chk($sformatf("tbl%0d_clear", i), out_valid, 0);
    end

    // backpressure: last pair of second vector stalls until result consumed
    out_ready = 1'b0;
    send_vec(1, 1);
    chk("stall_first_valid", out_valid, 1);
    for (int i = 0; i < 7; i++) begin
      send(2, 2);
      chk($sformatf("stall_cnt%0d", i), out_cnt, i + 1);
    end
    in_valid = 1'b1;
    in_x = 8'd2;
    in_c = 12'd2;
    #1;
    chk("stall_in_ready_low", in_ready, 0);
    step();
    step();
    chk("stall_hold_res", $signed(out_res), 8);
    chk("stall_hold_valid", out_valid, 1);
    chk("stall_hold_cnt", out_cnt, 7);
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_res", $signed(out_res), 32);
    step();
    chk("b2b_clear", out_valid, 0);

    // flush discards partial sum and the in-flight pair
    for (int i = 0; i < 3; i++) send(5, 5);
    chk("flush_pre_cnt", out_cnt, 3);
    flush = 1'b1;
    in_valid = 1'b1;
    in_x = 8'd9;
    in_c = 12'd9;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_cnt", out_cnt, 0);
    chk("flush_no_valid", out_valid, 0);
    send_vec(2, 3);
    chk("flush_res", $signed(out_res), 48);
    step();

    // asynchronous reset mid-vector with a pending result
    out_ready = 1'b0;
    send_vec(1, 1);
    for (int i = 0; i < 5; i++) send(3, 3);
    chk("arst_pre_cnt", out_cnt, 5);
    chk("arst_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_cnt", out_cnt, 0);
    chk("arst_res", out_res, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_vec(1, -1);
    chk("arst_next_res", $signed(out_res), -8);
    step();

    // random stream against a sum-of-products scoreboard
    macc = 0;
    mcnt = 0;
    pairs = 0;
    delivered = 0;
    cycles = 0;
    tog = 1'b1;
    while (delivered < 1000 && cycles < 60000) begin
      in_valid = (pairs < 8000) ? tog : 1'b0;
      tog = !tog;
      in_x = 8'($urandom);
      in_c = 12'($urandom);
      out_ready = (pairs < 8000) ? 1'($urandom_range(1, 0)) : 1'b1;
      #1;
      fin  = in_valid && in_ready;
      fout = out_valid && out_ready;
      if (fout) begin
        if (exp_q.size() == 0) chk("rand_spurious", 1, 0);
        else chk("rand_res", $signed(out_res), exp_q.pop_front());
        delivered++;
      end
      if (fin) begin
        sx = in_x;
        sc = in_c;
        macc += longint'(sx) * longint'(sc);
        mcnt++;
        pairs++;
        if (mcnt == 8) begin
          exp_q.push_back(macc);
          macc = 0;
          mcnt = 0;
        end
      end
      step();
      cycles++;
    end
    in_valid = 1'b0;
    chk("rand_delivered", delivered, 1000);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
